// File: rtl/bus_arbiter.sv
// Shares one AXI4-Lite master port between the fetch stage (reads only) and the
// mem stage (loads/stores). One transaction in flight; mem wins over fetch.
module bus_arbiter (
  input  logic        clk,
  input  logic        rstn,
  // fetch side
  input  logic        f_req_valid,
  input  logic [31:0] f_req_addr,
  output logic        f_req_ready,
  output logic        f_resp_valid,
  // mem side
  input  logic        m_req_valid,
  input  logic        m_req_we,
  input  logic [31:0] m_req_addr,
  input  logic [31:0] m_req_wdata,
  input  logic [3:0]  m_req_wstrb,
  output logic        m_req_ready,
  output logic        m_resp_valid,
  // shared response
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI4-Lite read address
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  output logic [2:0]  axi_arprot,
  input  logic        axi_arready,
  // AXI4-Lite read data
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  // AXI4-Lite write address
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  output logic [2:0]  axi_awprot,
  input  logic        axi_awready,
  // AXI4-Lite write data
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  // FSM state for checkers
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0]  r_state;
  logic        r_owner_f;
  logic [31:0] r_araddr;
  logic        r_arvalid;
  logic [2:0]  r_arprot;
  logic        r_rready;
  logic [31:0] r_awaddr;
  logic        r_awvalid;
  logic [2:0]  r_awprot;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_f_resp_valid;
  logic        r_m_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic w_idle;
  logic w_m_accept;
  logic w_f_accept;
  logic w_aw_done;
  logic w_w_done;

  // Every valid/ready pair is a plain AXI-style handshake: a transfer happens on
  // a rising clk edge where both are high; the source holds valid and payload
  // stable until then. Request readies are combinational, forced low in reset.
  assign w_idle      = (r_state == S_IDLE);
  assign w_m_accept  = rstn && w_idle && m_req_valid;
  assign w_f_accept  = rstn && w_idle && f_req_valid && !m_req_valid;
  assign w_aw_done   = !r_awvalid || axi_awready;
  assign w_w_done    = !r_wvalid  || axi_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_owner_f      <= 1'b0;
      r_araddr       <= '0;
      r_arvalid      <= 1'b0;
      r_arprot       <= '0;
      r_rready       <= 1'b0;
      r_awaddr       <= '0;
      r_awvalid      <= 1'b0;
      r_awprot       <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
      r_f_resp_valid <= 1'b0;
      r_m_resp_valid <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_err     <= 1'b0;
    end else begin
      r_f_resp_valid <= 1'b0;
      r_m_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_m_accept) begin
            r_owner_f <= 1'b0;
            if (m_req_we) begin
              r_awaddr  <= m_req_addr;
              r_awprot  <= 3'b000;
              r_awvalid <= 1'b1;
              r_wdata   <= m_req_wdata;
              r_wstrb   <= m_req_wstrb;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_araddr  <= m_req_addr;
              r_arprot  <= 3'b000;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end else if (w_f_accept) begin
            r_owner_f <= 1'b1;
            r_araddr  <= f_req_addr;
            r_arprot  <= 3'b100;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi_rvalid) begin
            r_rready       <= 1'b0;
            r_resp_rdata   <= axi_rdata;
            r_resp_err     <= (axi_rresp != 2'b00);
            r_f_resp_valid <= r_owner_f;
            r_m_resp_valid <= !r_owner_f;
            r_state        <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          // AW and W complete independently, in either order or together.
          if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi_bvalid) begin
            r_bready       <= 1'b0;
            r_resp_err     <= (axi_bresp != 2'b00);
            r_resp_rdata   <= '0;
            r_m_resp_valid <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign f_req_ready  = w_f_accept;
  assign m_req_ready  = w_m_accept;
  assign f_resp_valid = r_f_resp_valid;
  assign m_resp_valid = r_m_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign axi_araddr   = r_araddr;
  assign axi_arvalid  = r_arvalid;
  assign axi_arprot   = r_arprot;
  assign axi_rready   = r_rready;
  assign axi_awaddr   = r_awaddr;
  assign axi_awvalid  = r_awvalid;
  assign axi_awprot   = r_awprot;
  assign axi_wdata    = r_wdata;
  assign axi_wstrb    = r_wstrb;
  assign axi_wvalid   = r_wvalid;
  assign axi_bready   = r_bready;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: requester drivers, an AXI4-Lite slave model
// with programmable stalls, and a response scoreboard fed at request acceptance.
module tb_bus_arbiter;

  logic        clk;
  logic        rstn;
  logic        f_req_valid;
  logic [31:0] f_req_addr;
  logic        f_req_ready;
  logic        f_resp_valid;
  logic        m_req_valid;
  logic        m_req_we;
  logic [31:0] m_req_addr;
  logic [31:0] m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_req_ready;
  logic        m_resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic [2:0]  axi_arprot;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic [2:0]  axi_awprot;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [2:0]  dbg_state;

  bus_arbiter dut (
    .clk(clk), .rstn(rstn),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_resp_valid(f_resp_valid),
    .m_req_valid(m_req_valid), .m_req_we(m_req_we), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb), .m_req_ready(m_req_ready),
    .m_resp_valid(m_resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // response entry: {f_resp_valid, m_resp_valid, resp_err, resp_rdata}
  logic [34:0] exp_q[$];
  logic [34:0] exp_ar_q[$];  // {araddr, arprot}
  logic [34:0] exp_aw_q[$];  // {awaddr, awprot}
  logic [35:0] exp_w_q[$];   // {wdata, wstrb}

  int cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
  logic       cfg_r_hold = 1'b0;
  logic [1:0] cfg_rresp  = 2'b00;
  logic [1:0] cfg_bresp  = 2'b00;

  int f_accept_cyc = 0, m_accept_cyc = 0;
  int last_f_resp_cyc = 0, last_m_resp_cyc = 0;
  int resp_count = 0;
  int aw_hi_cnt = 0, w_hi_cnt = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] addr);
    return (addr == 32'h0000_0010) ? 32'hDEAD_BEEF : (addr ^ 32'hA5A5_0000);
  endfunction

  // ---------------- AXI4-Lite slave model ----------------
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] rd_addr;
    logic [34:0] e35;
    logic [35:0] e36;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; rd_addr = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0;
      end else begin
        if (axi_awvalid) aw_hi_cnt++;
        if (axi_wvalid)  w_hi_cnt++;
        if (axi_bready) chk("bready_after_aw_w", {axi_awvalid, axi_wvalid}, 2'b00);
        // read address: ready after cfg_ar_wait cycles of arvalid
        if (axi_arvalid) begin
          if (ar_cnt >= cfg_ar_wait) begin
            if (exp_ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
              e35 = exp_ar_q.pop_front();
              chk("ar_addr_prot", {axi_araddr, axi_arprot}, e35);
            end
            rd_addr = axi_araddr;
            axi_arready = 1;
          end else begin ar_cnt++; axi_arready = 0; end
        end else begin ar_cnt = 0; axi_arready = 0; end
        // read data
        if (axi_rready && !cfg_r_hold) begin
          if (r_cnt >= cfg_r_wait) begin
            axi_rvalid = 1; axi_rdata = slave_data(rd_addr); axi_rresp = cfg_rresp;
          end else begin r_cnt++; axi_rvalid = 0; end
        end else begin r_cnt = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0; end
        // write address
        if (axi_awvalid) begin
          if (aw_cnt >= cfg_aw_wait) begin
            if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
              e35 = exp_aw_q.pop_front();
              chk("aw_addr_prot", {axi_awaddr, axi_awprot}, e35);
            end
            axi_awready = 1;
          end else begin aw_cnt++; axi_awready = 0; end
        end else begin aw_cnt = 0; axi_awready = 0; end
        // write data
        if (axi_wvalid) begin
          if (w_cnt >= cfg_w_wait) begin
            if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
            else begin
              e36 = exp_w_q.pop_front();
              chk("w_data_strb", {axi_wdata, axi_wstrb}, e36);
            end
            axi_wready = 1;
          end else begin w_cnt++; axi_wready = 0; end
        end else begin w_cnt = 0; axi_wready = 0; end
        // write response
        if (axi_bready) begin
          if (b_cnt >= cfg_b_wait) begin axi_bvalid = 1; axi_bresp = cfg_bresp; end
          else begin b_cnt++; axi_bvalid = 0; end
        end else begin b_cnt = 0; axi_bvalid = 0; axi_bresp = '0; end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (f_resp_valid || m_resp_valid) begin
        resp_count++;
        if (f_resp_valid) last_f_resp_cyc = cyc;
        if (m_resp_valid) last_m_resp_cyc = cyc;
        if (exp_q.size() == 0) chk("resp_unexpected", {f_resp_valid, m_resp_valid}, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("resp", {f_resp_valid, m_resp_valid, resp_err, resp_rdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks (call just after a negedge) ----------------
  task automatic fetch_req(input logic [31:0] addr);
    int n;
    n = 0;
    f_req_valid = 1; f_req_addr = addr;
    #1;
    while (!f_req_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (!f_req_ready) begin
      chk("fetch_accept_timeout", 0, 1);
      f_req_valid = 0;
      return;
    end
    f_accept_cyc = cyc;
    exp_ar_q.push_back({addr, 3'b100});
    exp_q.push_back({2'b10, (cfg_rresp != 2'b00), slave_data(addr)});
    @(negedge clk);
    f_req_valid = 0; f_req_addr = '0;
  endtask

  task automatic mem_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    n = 0;
    m_req_valid = 1; m_req_we = we; m_req_addr = addr;
    m_req_wdata = wdata; m_req_wstrb = wstrb;
    #1;
    while (!m_req_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (!m_req_ready) begin
      chk("mem_accept_timeout", 0, 1);
      m_req_valid = 0;
      return;
    end
    m_accept_cyc = cyc;
    if (we) begin
      exp_aw_q.push_back({addr, 3'b000});
      exp_w_q.push_back({wdata, wstrb});
      exp_q.push_back({2'b01, (cfg_bresp != 2'b00), 32'h0});
    end else begin
      exp_ar_q.push_back({addr, 3'b000});
      exp_q.push_back({2'b01, (cfg_rresp != 2'b00), slave_data(addr)});
    end
    @(negedge clk);
    m_req_valid = 0; m_req_we = 0; m_req_addr = '0; m_req_wdata = '0; m_req_wstrb = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk(name, exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {f_req_ready, f_resp_valid, m_req_ready, m_resp_valid, resp_rdata, resp_err,
                axi_araddr, axi_arvalid, axi_arprot, axi_rready,
                axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid,
                axi_bready, dbg_state}, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rstn = 0;
    f_req_valid = 0; f_req_addr = '0;
    m_req_valid = 0; m_req_we = 0; m_req_addr = '0; m_req_wdata = '0; m_req_wstrb = '0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset_outputs");
    @(negedge clk); rstn = 1;
    repeat (2) @(negedge clk);

    // 1: fetch read, zero-wait slave
    fetch_req(32'h0000_0010);
    wait_drain("fetch_drain");
    chk("fetch_latency", last_f_resp_cyc - f_accept_cyc, 3);

    // 2: simultaneous requests, mem wins; fetch accepted in m_resp_valid cycle
    fork
      mem_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
      fetch_req(32'h0000_0300);
      begin
        #1;
        chk("prio_m_ready", m_req_ready, 1);
        chk("prio_f_ready", f_req_ready, 0);
      end
    join
    wait_drain("prio_drain");
    chk("fetch_accept_in_mresp_cycle", f_accept_cyc, last_m_resp_cyc);

    // 3: write, awready delayed, wready immediate
    cfg_aw_wait = 2;
    aw_hi_cnt = 0; w_hi_cnt = 0;
    mem_req(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
    wait_drain("write_drain");
    chk("awvalid_cycles", aw_hi_cnt, 3);
    chk("wvalid_cycles", w_hi_cnt, 1);
    cfg_aw_wait = 0;

    // 4: error responses, with read-side stalls
    cfg_rresp = 2'b10; cfg_ar_wait = 1; cfg_r_wait = 2;
    mem_req(1'b0, 32'h0000_0400, 32'h0, 4'h0);
    wait_drain("rd_err_drain");
    cfg_rresp = 2'b00; cfg_ar_wait = 0; cfg_r_wait = 0;
    cfg_bresp = 2'b11; cfg_w_wait = 2; cfg_b_wait = 1;
    mem_req(1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'b1111);
    wait_drain("wr_err_drain");
    cfg_bresp = 2'b00; cfg_w_wait = 0; cfg_b_wait = 0;

    // 5: reset while waiting for rvalid
    cfg_r_hold = 1'b1;
    fetch_req(32'h0000_0040);
    n = 0;
    while (!axi_rready && n < 50) begin @(negedge clk); n++; end
    chk("reached_rd_data", dbg_state, 3'd2);
    #2 rstn = 0;
    #1 chk_all_zero("async_reset_outputs");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1; cfg_r_hold = 1'b0;
    resp_count = 0;
    repeat (6) @(negedge clk);
    chk("no_stale_resp", resp_count, 0);
    fetch_req(32'h0000_0010);
    wait_drain("post_reset_drain");
    chk("post_reset_resp_count", resp_count, 1);
    chk("ar_queue_empty", exp_ar_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
